// File: rtl/spi_ram_arbiter_ctrl_if.sv
// CPU-side bus of spi_ram_arbiter_ctrl: instruction-fetch port and data port.
interface spi_ram_arbiter_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rstrb;
  logic [31:0]           if_rdata;
  logic                  if_rbusy;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic [3:0]            d_wmask;
  logic                  d_rstrb;
  logic [31:0]           d_rdata;
  logic                  d_rbusy;
  logic                  d_wbusy;

  modport master (
    output if_addr, if_rstrb, d_addr, d_wdata, d_wmask, d_rstrb,
    input  if_rdata, if_rbusy, d_rdata, d_rbusy, d_wbusy
  );
  modport slave (
    input  if_addr, if_rstrb, d_addr, d_wdata, d_wmask, d_rstrb,
    output if_rdata, if_rbusy, d_rdata, d_rbusy, d_wbusy
  );
endinterface

// File: rtl/spi_ram_arbiter_ctrl.sv
// SPI SRAM sequencer shared by the fetch and data ports (data has priority).
// Define SPI_RAM_FASTREAD_EN to read with FAST READ 0x0B plus 8 dummy bits.
module spi_ram_arbiter_ctrl #(
  parameter int unsigned CS_IDLE_CYCLES = 2,
  parameter int unsigned ADDR_WIDTH     = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  spi_ram_arbiter_ctrl_if.slave        bus,
  output logic                         spi_clk_ram,
  output logic                         spi_cs_n_ram,
  output logic                         spi_mosi_ram,
  input  logic                         spi_miso_ram
);
  localparam int unsigned AW  = ADDR_WIDTH;
  localparam int unsigned ICW = $clog2(CS_IDLE_CYCLES + 1);
`ifdef SPI_RAM_FASTREAD_EN
  localparam logic [7:0] RD_CMD   = 8'h0B;
  localparam logic       RD_DUMMY = 1'b1;
`else
  localparam logic [7:0] RD_CMD   = 8'h03;
  localparam logic       RD_DUMMY = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d, data_last_q, data_last_d;
  logic [63:0]     tx_q, tx_d;
  logic [31:0]     rx_q, rx_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
  logic            cur_data_q, cur_data_d, cur_write_q, cur_write_d;
  logic            if_pend_q, if_pend_d, if_busy_q, if_busy_d;
  logic [AW-1:0]   if_addr_q, if_addr_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            d_pend_q, d_pend_d, d_rbusy_q, d_rbusy_d, d_wbusy_q, d_wbusy_d;
  logic [AW-1:0]   d_addr_q, d_addr_d;
  logic [31:0]     d_wdata_q, d_wdata_d, d_rdata_q, d_rdata_d;
  logic [3:0]      d_wmask_q, d_wmask_d;

  logic            if_take, d_wtake, d_rtake, d_take, idle_ok, found;
  logic            if_pend_eff, d_pend_eff;
  logic [AW-1:0]   if_addr_eff, d_addr_eff;
  logic [31:0]     d_wdata_eff, shifted;
  logic [3:0]      d_wmask_eff;
  logic [1:0]      lane_lo;
  logic [2:0]      nb;
  logic [5:0]      last_tmp;

  function automatic logic [23:0] pad_addr(input logic [AW-1:0] a, input logic [1:0] lo);
    logic [23:0] r;
    r = '0;
    r[AW-1:0] = a;
    r[1:0] = lo;
    return r;
  endfunction

  // Lowest RAM address travels first on the wire, so byte lanes are reversed.
  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    data_last_d = data_last_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    idle_cnt_d  = idle_cnt_q;
    cur_data_d  = cur_data_q;
    cur_write_d = cur_write_q;
    if_pend_d   = if_pend_q;
    if_busy_d   = if_busy_q;
    if_addr_d   = if_addr_q;
    if_rdata_d  = if_rdata_q;
    d_pend_d    = d_pend_q;
    d_rbusy_d   = d_rbusy_q;
    d_wbusy_d   = d_wbusy_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_wmask_d   = d_wmask_q;
    d_rdata_d   = d_rdata_q;

    if_take = bus.if_rstrb && !if_busy_q;
    d_wtake = !d_rbusy_q && !d_wbusy_q && (bus.d_wmask != '0);
    d_rtake = !d_rbusy_q && !d_wbusy_q && bus.d_rstrb && (bus.d_wmask == '0);
    d_take  = d_wtake || d_rtake;

    // A strobe arriving while idle is served in its own cycle, so merge it here.
    if_pend_eff = if_pend_q || if_take;
    if_addr_eff = if_take ? bus.if_addr : if_addr_q;
    d_pend_eff  = d_pend_q || d_take;
    d_addr_eff  = d_take ? bus.d_addr  : d_addr_q;
    d_wdata_eff = d_take ? bus.d_wdata : d_wdata_q;
    d_wmask_eff = d_take ? bus.d_wmask : d_wmask_q;

    lane_lo = '0;
    found   = 1'b0;
    nb      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (d_wmask_eff[k]) begin
        nb = nb + 3'd1;
        if (!found) begin
          lane_lo = 2'(k);
          found   = 1'b1;
        end
      end
    end
    shifted  = d_wdata_eff >> {lane_lo, 3'b000};
    last_tmp = {nb, 3'b000} - 6'd1;
    idle_ok  = (32'(idle_cnt_q) + 32'd1) >= CS_IDLE_CYCLES;

    if (if_take) begin
      if_pend_d = 1'b1;
      if_busy_d = 1'b1;
      if_addr_d = bus.if_addr;
    end
    if (d_take) begin
      d_pend_d  = 1'b1;
      d_wbusy_d = d_wtake;
      d_rbusy_d = d_rtake;
      d_addr_d  = bus.d_addr;
      d_wdata_d = bus.d_wdata;
      d_wmask_d = bus.d_wmask;
    end

    case (state_q)
      S_IDLE: begin
        if (32'(idle_cnt_q) < CS_IDLE_CYCLES) idle_cnt_d = idle_cnt_q + ICW'(1);
        if (idle_ok && (d_pend_eff || if_pend_eff)) begin
          state_d     = S_CMD;
          phase_d     = 1'b0;
          bit_cnt_d   = '0;
          idle_cnt_d  = '0;
          data_last_d = 5'd31;
          if (d_pend_eff) begin
            d_pend_d    = 1'b0;
            cur_data_d  = 1'b1;
            cur_write_d = (d_wmask_eff != '0);
            if (d_wmask_eff != '0) begin
              tx_d        = {8'h02, pad_addr(d_addr_eff, lane_lo), swap32(shifted)};
              data_last_d = last_tmp[4:0];
            end else begin
              tx_d = {RD_CMD, pad_addr(d_addr_eff, 2'b00), 32'h0};
            end
          end else begin
            if_pend_d   = 1'b0;
            cur_data_d  = 1'b0;
            cur_write_d = 1'b0;
            tx_d        = {RD_CMD, pad_addr(if_addr_eff, 2'b00), 32'h0};
          end
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (state_q != S_DUMMY) tx_d = {tx_q[62:0], 1'b0};
          if (state_q == S_DATA)  rx_d = {rx_q[30:0], spi_miso_ram};
          bit_cnt_d = bit_cnt_q + 5'd1;
          case (state_q)
            S_CMD: if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = S_ADDR;
            end
            S_ADDR: if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              state_d   = (RD_DUMMY && !cur_write_q) ? S_DUMMY : S_DATA;
            end
            S_DUMMY: if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = S_DATA;
            end
            default: if (bit_cnt_q == data_last_q) begin
              bit_cnt_d = '0;
              state_d   = S_DONE;
            end
          endcase
        end
      end
      default: begin
        state_d    = S_IDLE;
        idle_cnt_d = ICW'(1);
        if (cur_data_q) begin
          if (cur_write_q) begin
            d_wbusy_d = 1'b0;
          end else begin
            d_rbusy_d = 1'b0;
            d_rdata_d = swap32(rx_q);
          end
        end else begin
          if_busy_d  = 1'b0;
          if_rdata_d = swap32(rx_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      bit_cnt_q   <= '0;
      data_last_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      idle_cnt_q  <= ICW'(CS_IDLE_CYCLES);
      cur_data_q  <= 1'b0;
      cur_write_q <= 1'b0;
      if_pend_q   <= 1'b0;
      if_busy_q   <= 1'b0;
      if_addr_q   <= '0;
      if_rdata_q  <= '0;
      d_pend_q    <= 1'b0;
      d_rbusy_q   <= 1'b0;
      d_wbusy_q   <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wmask_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      data_last_q <= data_last_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      idle_cnt_q  <= idle_cnt_d;
      cur_data_q  <= cur_data_d;
      cur_write_q <= cur_write_d;
      if_pend_q   <= if_pend_d;
      if_busy_q   <= if_busy_d;
      if_addr_q   <= if_addr_d;
      if_rdata_q  <= if_rdata_d;
      d_pend_q    <= d_pend_d;
      d_rbusy_q   <= d_rbusy_d;
      d_wbusy_q   <= d_wbusy_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wmask_q   <= d_wmask_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    spi_cs_n_ram = !(state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
    spi_clk_ram  = !spi_cs_n_ram && phase_q;
    spi_mosi_ram = !spi_cs_n_ram && (state_q != S_DUMMY) && tx_q[63];
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_rbusy = if_busy_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_rbusy  = d_rbusy_q;
  assign bus.d_wbusy  = d_wbusy_q;
endmodule

// File: tb/tb_spi_ram_arbiter_ctrl.sv
// Directed bench for spi_ram_arbiter_ctrl with a behavioural SPI SRAM and byte/word scoreboards.
`timescale 1ns/1ps
module tb_spi_ram_arbiter_ctrl;
`ifdef SPI_RAM_FASTREAD_EN
  localparam int         RD_LAT = 146;
  localparam logic [7:0] RD_CMD = 8'h0B;
  localparam bit         FAST   = 1'b1;
`else
  localparam int         RD_LAT = 130;
  localparam logic [7:0] RD_CMD = 8'h03;
  localparam bit         FAST   = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk_ram, spi_cs_n_ram, spi_mosi_ram;
  logic spi_miso_ram = 1'b0;

  always #5 clk = ~clk;

  spi_ram_arbiter_ctrl_if #(.ADDR_WIDTH(24)) bus ();

  spi_ram_arbiter_ctrl #(.CS_IDLE_CYCLES(2), .ADDR_WIDTH(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .spi_clk_ram  (spi_clk_ram),
    .spi_cs_n_ram (spi_cs_n_ram),
    .spi_mosi_ram (spi_mosi_ram),
    .spi_miso_ram (spi_miso_ram)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_bytes[$];
  logic [7:0]  got_bytes[$];
  logic [31:0] exp_words[$];
  logic [7:0]  exp_mem[int];

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) % 256);
  endfunction

  // SPI SRAM model, mode 0: samples mosi on SCK rise, shifts miso on SCK fall.
  logic [7:0]  ram[int];
  logic        sck_prev = 1'b0, cs_prev = 1'b1;
  int          nbit, nbyte, hdr, j, idx;
  logic [7:0]  sh, cmd, b;
  logic [23:0] maddr;

  always @(spi_clk_ram or spi_cs_n_ram) begin
    if (cs_prev === 1'b1 && spi_cs_n_ram === 1'b0) begin
      nbit = 0; nbyte = 0; hdr = 4; cmd = 8'h00; maddr = '0; sh = 8'h00;
    end
    if (spi_cs_n_ram === 1'b0 && sck_prev === 1'b0 && spi_clk_ram === 1'b1) begin
      sh = {sh[6:0], spi_mosi_ram};
      nbit++;
      if (nbit % 8 == 0) begin
        if (nbyte == 0) begin
          cmd = sh;
          hdr = (sh == 8'h0B) ? 5 : 4;
        end else if (nbyte <= 3) begin
          maddr = {maddr[15:0], sh};
        end
        if (nbyte < hdr || cmd == 8'h02) got_bytes.push_back(sh);
        if (cmd == 8'h02 && nbyte >= 4) begin
          ram[int'(maddr) & 1023] = sh;
          maddr = maddr + 24'd1;
        end
        nbyte++;
      end
    end
    if (spi_cs_n_ram === 1'b0 && sck_prev === 1'b1 && spi_clk_ram === 1'b0) begin
      if (cmd != 8'h02 && nbyte >= hdr) begin
        j   = nbit - hdr * 8;
        idx = (int'(maddr) + j / 8) & 1023;
        b   = ram.exists(idx) ? ram[idx] : pat(idx);
        spi_miso_ram <= b[7 - (j % 8)];
      end
    end
    sck_prev = spi_clk_ram;
    cs_prev  = spi_cs_n_ram;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    int base;
    logic [31:0] w;
    base = int'({a[23:2], 2'b00}) & 1023;
    w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = exp_mem.exists(base + k) ? exp_mem[base + k] : pat(base + k);
    return w;
  endfunction

  task automatic push_rd_frame(input logic [23:0] a);
    exp_bytes.push_back(RD_CMD);
    exp_bytes.push_back(a[23:16]);
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back({a[7:2], 2'b00});
    if (FAST) exp_bytes.push_back(8'h00);
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [3:0] wm, input logic [31:0] wd);
    logic [1:0] lo;
    int base;
    lo = 2'd0;
    for (int k = 3; k >= 0; k--) if (wm[k]) lo = 2'(k);
    base = int'({a[23:2], 2'b00}) & 1023;
    exp_bytes.push_back(8'h02);
    exp_bytes.push_back(a[23:16]);
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back({a[7:2], lo});
    for (int k = 0; k < 4; k++) begin
      if (wm[k]) begin
        exp_bytes.push_back(wd[8*k +: 8]);
        exp_mem[base + k] = wd[8*k +: 8];
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] e, g;
    int n;
    n = 0;
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      g = (got_bytes.size() > 0) ? got_bytes.pop_front() : 8'hxx;
      check($sformatf("%s_byte%0d", tag, n), 32'(g), 32'(e));
      n++;
    end
    check({tag, "_extra_bytes"}, 32'(got_bytes.size()), 32'd0);
    got_bytes.delete();
  endtask

  function automatic logic busy_of(input int which);
    case (which)
      0:       return bus.if_rbusy;
      1:       return bus.d_rbusy;
      default: return bus.d_wbusy;
    endcase
  endfunction

  task automatic issue(input logic ir, input logic [23:0] ia, input logic dr,
                       input logic [3:0] wm, input logic [23:0] da, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.if_rstrb = ir; bus.if_addr = ia;
    bus.d_rstrb = dr; bus.d_wmask = wm; bus.d_addr = da; bus.d_wdata = wd;
  endtask

  task automatic drop_strobes();
    bus.if_rstrb = 1'b0;
    bus.d_rstrb  = 1'b0;
    bus.d_wmask  = 4'h0;
  endtask

  task automatic run_wait(input int which, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        drop_strobes();
        check1({tag, "_cs_n_cycle1"}, spi_cs_n_ram, 1'b0);
        check1({tag, "_busy_cycle1"}, busy_of(which), 1'b1);
      end
      if (busy_of(which) == 1'b0) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  int   cs_rise, cs_fall2, d_low, if_low;
  logic prev_cs;

  initial begin
    bus.if_rstrb = 1'b0; bus.if_addr = '0;
    bus.d_rstrb = 1'b0; bus.d_wmask = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check1("rst_cs_n", spi_cs_n_ram, 1'b1);
    check1("rst_sck", spi_clk_ram, 1'b0);
    check1("rst_mosi", spi_mosi_ram, 1'b0);
    check1("rst_if_rbusy", bus.if_rbusy, 1'b0);
    check1("rst_d_rbusy", bus.d_rbusy, 1'b0);
    check1("rst_d_wbusy", bus.d_wbusy, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);

    // Full-word write, then fetch it back (fetch address low bits ignored).
    push_wr(24'h000100, 4'hF, 32'hDEADBEEF);
    issue(1'b0, '0, 1'b0, 4'hF, 24'h000100, 32'hDEADBEEF);
    run_wait(2, 130, "wr_full");
    check_frame("wr_full_frame");

    push_rd_frame(24'h000103);
    exp_words.push_back(32'hDEADBEEF);
    issue(1'b1, 24'h000103, 1'b0, 4'h0, '0, '0);
    run_wait(0, RD_LAT, "if_rd");
    check("if_rd_data", bus.if_rdata, exp_words.pop_front());
    check_frame("if_rd_frame");

    // Single-byte write in lane 2, then data-port read.
    push_wr(24'h000100, 4'b0100, 32'h00AA0000);
    issue(1'b0, '0, 1'b0, 4'b0100, 24'h000100, 32'h00AA0000);
    run_wait(2, 82, "wr_lane2");
    check_frame("wr_lane2_frame");

    push_rd_frame(24'h000100);
    exp_words.push_back(32'hDEAABEEF);
    issue(1'b0, '0, 1'b1, 4'h0, 24'h000100, '0);
    run_wait(1, RD_LAT, "d_rd");
    check("d_rd_data", bus.d_rdata, exp_words.pop_front());
    check("if_rdata_held", bus.if_rdata, 32'hDEADBEEF);
    check_frame("d_rd_frame");

    // Middle-lane and top-lane partial writes.
    push_wr(24'h000204, 4'b0110, 32'h12345678);
    issue(1'b0, '0, 1'b0, 4'b0110, 24'h000204, 32'h12345678);
    run_wait(2, 2 + 16 * 6, "wr_mid");
    check_frame("wr_mid_frame");

    push_wr(24'h00020C, 4'b1000, 32'hA5000000);
    issue(1'b0, '0, 1'b0, 4'b1000, 24'h00020C, 32'hA5000000);
    run_wait(2, 82, "wr_top");
    check_frame("wr_top_frame");

    // Write mask together with read strobe: only the write happens.
    push_wr(24'h000300, 4'b0001, 32'h000000C3);
    issue(1'b0, '0, 1'b1, 4'b0001, 24'h000300, 32'h000000C3);
    run_wait(2, 82, "wr_and_rd");
    check1("wr_and_rd_no_rbusy", bus.d_rbusy, 1'b0);
    check_frame("wr_and_rd_frame");

    // Simultaneous requests: data first, fetch after the CS idle gap.
    push_rd_frame(24'h000204);
    push_rd_frame(24'h00020C);
    exp_words.push_back(ref_word(24'h000204));
    exp_words.push_back(ref_word(24'h00020C));
    issue(1'b1, 24'h00020C, 1'b1, 4'h0, 24'h000204, '0);
    cs_rise = -1; cs_fall2 = -1; d_low = -1; if_low = -1; prev_cs = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clk); #1;
      if (i == 1) drop_strobes();
      if (prev_cs == 1'b0 && spi_cs_n_ram == 1'b1 && cs_rise < 0) cs_rise = i;
      if (prev_cs == 1'b1 && spi_cs_n_ram == 1'b0 && cs_rise >= 0 && cs_fall2 < 0) cs_fall2 = i;
      prev_cs = spi_cs_n_ram;
      if (d_low < 0 && bus.d_rbusy == 1'b0) begin
        d_low = i;
        check("both_d_rdata", bus.d_rdata, exp_words.pop_front());
      end
      if (if_low < 0 && bus.if_rbusy == 1'b0) begin
        if_low = i;
        check("both_if_rdata", bus.if_rdata, exp_words.pop_front());
        break;
      end
    end
    check("both_data_cs_rise", 32'(cs_rise), 32'(RD_LAT - 1));
    check("both_fetch_cs_fall", 32'(cs_fall2), 32'(RD_LAT + 1));
    check("both_d_latency", 32'(d_low), 32'(RD_LAT));
    check("both_if_latency", 32'(if_low), 32'(2 * RD_LAT));
    check_frame("both_frames");
    exp_words.delete();

    // Reset during the address phase of a read.
    issue(1'b0, '0, 1'b1, 4'h0, 24'h000100, '0);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i == 1) drop_strobes();
    end
    check1("pre_rst_cs_low", spi_cs_n_ram, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check1("mid_rst_cs_n", spi_cs_n_ram, 1'b1);
    check1("mid_rst_sck", spi_clk_ram, 1'b0);
    check1("mid_rst_d_rbusy", bus.d_rbusy, 1'b0);
    check("mid_rst_d_rdata", bus.d_rdata, 32'h0);
    check("mid_rst_if_rdata", bus.if_rdata, 32'h0);
    reset = 1'b0;
    got_bytes.delete();
    repeat (2) @(posedge clk);
    push_rd_frame(24'h000100);
    exp_words.push_back(32'hDEAABEEF);
    issue(1'b0, '0, 1'b1, 4'h0, 24'h000100, '0);
    run_wait(1, RD_LAT, "rd_after_rst");
    check("rd_after_rst_data", bus.d_rdata, exp_words.pop_front());
    check_frame("rd_after_rst_frame");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
